// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, handshakes with a variable-latency
// memory through mem_ready_i (with optional timeout) and counts retired instructions.
// Optional feature: define MIPS_CTRL_ADDI_EN to add the addi path (states 10 and 11).
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned MEM_TMO = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic             mem_tmo_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  // Wait counter only has to reach MEM_TMO-1.
  localparam int unsigned WaitW      = (MEM_TMO > 2) ? $clog2(MEM_TMO) : 1;
  localparam int unsigned TmoLastInt = (MEM_TMO == 0) ? 0 : MEM_TMO - 1;
  localparam logic [WaitW-1:0] TmoLast = WaitW'(TmoLastInt);

  state_e             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_state, tmo_hit, retire;
  logic               pc_write, pc_write_cond;

  assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // A same-cycle mem_ready beats the timeout.
  assign tmo_hit   = (MEM_TMO != 0) && mem_state && !mem_ready_i && (wait_q == TmoLast);

  // State, latched opcode, wait counter and retire counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StFetch;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, retire decision and wait-counter update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (mem_ready_i)  state_d = StDecode;
        else if (tmo_hit) state_d = StFetch;
      end
      StDecode: begin
        op_d = opcode_i;
        case (opcode_i)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
`ifdef MIPS_CTRL_ADDI_EN
          OpAddi:     state_d = StAddiEx;
`endif
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready_i)  state_d = StMemWb;
        else if (tmo_hit) state_d = StFetch;
      end
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: begin
        if (mem_ready_i || tmo_hit) state_d = StFetch;
        retire = mem_ready_i;
      end
      StExec:   state_d = StAluWb;
      StAluWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StBranch, StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
`ifdef MIPS_CTRL_ADDI_EN
      StAddiEx: state_d = StAddiWb;
      StAddiWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
`endif
      default:  state_d = StFetch;
    endcase
    // Counter is zero on every entry to a memory-wait state since it clears on exit.
    wait_d = (mem_state && !mem_ready_i && !tmo_hit) ? wait_q + WaitW'(1) : '0;
    cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Datapath controls decoded from the current state; enables squashed during reset.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d_o      = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    reg_write_o   = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'b00;
    alu_op_o      = 2'b00;
    pc_source_o   = 2'b00;
    illegal_o     = 1'b0;
    mem_tmo_o     = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write    = mem_ready_i;
        mem_tmo_o   = tmo_hit;
      end
      StDecode: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OpLw, OpSw, OpRtype, OpBeq, OpJ: illegal_o = 1'b0;
`ifdef MIPS_CTRL_ADDI_EN
          OpAddi:                          illegal_o = 1'b0;
`endif
          default:                         illegal_o = 1'b1;
        endcase
      end
      StMemAdr, StAddiEx: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      StMemRd: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        mem_tmo_o  = tmo_hit;
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      StMemWr: begin
        mem_write_o = !tmo_hit;
        i_or_d_o    = 1'b1;
        mem_tmo_o   = tmo_hit;
      end
      StExec: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
      end
      StAluWb: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      StBranch: begin
        alu_src_a_o   = 1'b1;
        alu_op_o      = 2'b01;
        pc_write_cond = 1'b1;
        pc_source_o   = 2'b01;
      end
      StJump: begin
        pc_write    = 1'b1;
        pc_source_o = 2'b10;
      end
      StAddiWb: reg_write_o = 1'b1;
      default: ;
    endcase
    pc_en_o = pc_write | (pc_write_cond & zero_i);
    if (reset_i) begin
      pc_en_o     = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      ir_write_o  = 1'b0;
      reg_write_o = 1'b0;
      illegal_o   = 1'b0;
      mem_tmo_o   = 1'b0;
    end
  end

  assign state_o     = state_q;
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: each instruction is expanded into an
// expected per-cycle trace (state, handshake, retire) and compared cycle by cycle.
module tb_mips_multicycle_ctrl;

  localparam int unsigned CntW   = 4;
  localparam int unsigned MemTmo = 4;

  localparam logic [5:0] OpR   = 6'b000000;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpJ   = 6'b000010;
  localparam logic [5:0] OpAdi = 6'b001000;
  localparam logic [5:0] OpBad = 6'b111111;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] opcode;
  logic pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic alu_src_a, illegal, mem_tmo;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [CntW-1:0] instr_cnt;
  logic [31:0] obs_ctrl;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(CntW), .MEM_TMO(MemTmo)) dut (
    .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(mem_ready),
    .pc_en_o(pc_en), .i_or_d_o(i_or_d), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .ir_write_o(ir_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .alu_op_o(alu_op), .pc_source_o(pc_source), .state_o(state), .illegal_o(illegal),
    .mem_tmo_o(mem_tmo), .instr_cnt_o(instr_cnt)
  );

  assign obs_ctrl = {15'd0, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal, mem_tmo};

  int total = 0;
  int bad   = 0;
  int model_cnt;

  typedef struct {
    int st;
    bit rdy;
    bit tmo;
    bit ill;
    bit ret;
  } cyc_t;
  cyc_t trace[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Control word required in a given state.
  function automatic logic [31:0] exp_ctrl(int st, bit rdy, bit tmo, bit ill, bit z, bit rst);
    logic pe, iod, mr, mw, irw, rd, m2r, rw, sa, il, mt;
    logic [1:0] sb, aop, ps;
    {pe, iod, mr, mw, irw, rd, m2r, rw, sa, il, mt} = '0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pe = rdy; mt = tmo; end
      1:  begin sb = 2'b11; il = ill; end
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iod = 1; mt = tmo; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = !tmo; iod = 1; mt = tmo; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; ps = 2'b01; pe = z; end
      9:  begin pe = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    if (rst) {pe, mr, mw, irw, rw, il, mt} = '0;
    return {15'd0, pe, iod, mr, mw, irw, rd, m2r, rw, sa, sb, aop, ps, il, mt};
  endfunction

  function automatic void push(int st, bit rdy, bit tmo, bit ill, bit ret);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.tmo = tmo; c.ill = ill; c.ret = ret;
    trace.push_back(c);
  endfunction

  task automatic step_raw(int st, bit rdy, bit tmo, bit ill, bit ret, bit z,
                          logic [5:0] op, bit rst);
    @(negedge clk);
    reset     = rst;
    mem_ready = rdy;
    zero      = z;
    opcode    = (st == 0) ? 6'($urandom) : op;
    #1;
    check_eq($sformatf("state(op=%b)", op), 32'(state), 32'(st));
    check_eq($sformatf("ctrl st%0d", st), obs_ctrl, exp_ctrl(st, rdy, tmo, ill, z, rst));
    check_eq($sformatf("cnt st%0d", st), 32'(instr_cnt), 32'(model_cnt));
    if (ret && !rst) model_cnt = (model_cnt + 1) % (1 << CntW);
  endtask

  // f: FETCH cycles without mem_ready; m: MEMRD/MEMWR cycles without mem_ready.
  task automatic run_instr(logic [5:0] op, int f, int m, bit z);
    int ms;
    trace.delete();
    while (f >= int'(MemTmo)) begin
      for (int i = 0; i < int'(MemTmo) - 1; i++) push(0, 0, 0, 0, 0);
      push(0, 0, 1, 0, 0);
      f -= MemTmo;
    end
    for (int i = 0; i < f; i++) push(0, 0, 0, 0, 0);
    push(0, 1, 0, 0, 0);
    if (op == OpLw || op == OpSw) begin
      push(1, 1'($urandom), 0, 0, 0);
      push(2, 1'($urandom), 0, 0, 0);
      ms = (op == OpLw) ? 3 : 5;
      if (m >= int'(MemTmo)) begin
        for (int i = 0; i < int'(MemTmo) - 1; i++) push(ms, 0, 0, 0, 0);
        push(ms, 0, 1, 0, 0);
      end else begin
        for (int i = 0; i < m; i++) push(ms, 0, 0, 0, 0);
        push(ms, 1, 0, 0, op == OpSw);
        if (op == OpLw) push(4, 1'($urandom), 0, 0, 1);
      end
    end else if (op == OpR) begin
      push(1, 1'($urandom), 0, 0, 0);
      push(6, 1'($urandom), 0, 0, 0);
      push(7, 1'($urandom), 0, 0, 1);
    end else if (op == OpBeq) begin
      push(1, 1'($urandom), 0, 0, 0);
      push(8, 1'($urandom), 0, 0, 1);
    end else if (op == OpJ) begin
      push(1, 1'($urandom), 0, 0, 0);
      push(9, 1'($urandom), 0, 0, 1);
`ifdef MIPS_CTRL_ADDI_EN
    end else if (op == OpAdi) begin
      push(1, 1'($urandom), 0, 0, 0);
      push(10, 1'($urandom), 0, 0, 0);
      push(11, 1'($urandom), 0, 0, 1);
`endif
    end else begin
      push(1, 1'($urandom), 0, 1, 0);
    end
    foreach (trace[i])
      step_raw(trace[i].st, trace[i].rdy, trace[i].tmo, trace[i].ill, trace[i].ret, z, op, 0);
  endtask

  initial begin
    logic [5:0] op;
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; model_cnt = 0;
    @(posedge clk);
    // Reset holds FETCH with enables squashed even while mem_ready is high.
    step_raw(0, 1, 0, 0, 0, 0, OpR, 1);
    step_raw(0, 1, 0, 0, 0, 1, OpR, 1);

    run_instr(OpR, 0, 0, 0);
    run_instr(OpLw, 0, 3, 0);
    run_instr(OpBeq, 1, 0, 1);
    run_instr(OpBeq, 0, 0, 0);
    run_instr(OpBad, 0, 0, 0);
    run_instr(OpSw, 0, 9, 0);
    run_instr(OpLw, 2, 4, 1);
    run_instr(OpSw, 3, 3, 0);
    run_instr(OpJ, 5, 0, 0);
    run_instr(OpAdi, 0, 0, 1);

    // Reset in MEMWR with mem_ready high: no write, no retire, counter cleared.
    step_raw(0, 1, 0, 0, 0, 0, OpSw, 0);
    step_raw(1, 0, 0, 0, 0, 0, OpSw, 0);
    step_raw(2, 0, 0, 0, 0, 0, OpSw, 0);
    step_raw(5, 0, 0, 0, 0, 0, OpSw, 0);
    step_raw(5, 1, 0, 0, 0, 0, OpSw, 1);
    model_cnt = 0;
    step_raw(0, 1, 0, 0, 0, 0, OpSw, 1);

    repeat (70) begin
      case ($urandom_range(0, 7))
        0: op = OpLw;
        1: op = OpSw;
        2: op = OpR;
        3: op = OpBeq;
        4: op = OpJ;
        5: op = OpAdi;
        6: op = 6'($urandom);
        default: op = OpBad;
      endcase
      run_instr(op, $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
